// File: rtl/ofs_plat_avalon_mem_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM bank among NUM_REQ requesters, with read-response routing.
// Define OFS_PLAT_AVALON_MEM_ARB_STATS_EN to build the per-requester grant counters on stat_grants.
module ofs_plat_avalon_mem_rr_arbiter #(
    parameter int NUM_REQ             = 2,
    parameter int ADDR_WIDTH          = 27,
    parameter int DATA_WIDTH          = 512,
    parameter int BURST_CNT_WIDTH     = 7,
    parameter int MAX_READS_IN_FLIGHT = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_address,
    input  logic [NUM_REQ-1:0]                 req_read,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*BURST_CNT_WIDTH-1:0] req_burstcount,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_writedata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]    req_byteenable,
    output logic [NUM_REQ-1:0]                 req_waitrequest,
    output logic [DATA_WIDTH-1:0]              req_readdata,
    output logic [NUM_REQ-1:0]                 req_readdatavalid,
    output logic [ADDR_WIDTH-1:0]              mem_address,
    output logic                               mem_read,
    output logic                               mem_write,
    output logic [BURST_CNT_WIDTH-1:0]         mem_burstcount,
    output logic [DATA_WIDTH-1:0]              mem_writedata,
    output logic [DATA_WIDTH/8-1:0]            mem_byteenable,
    input  logic                               mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]              mem_readdata,
    input  logic                               mem_readdatavalid,
    output logic [NUM_REQ*32-1:0]              stat_grants
);

    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int FIFO_AW = (MAX_READS_IN_FLIGHT > 1) ? $clog2(MAX_READS_IN_FLIGHT) : 1;
    localparam int CNT_W   = FIFO_AW + 1;
    localparam int BE_W    = DATA_WIDTH / 8;

    localparam logic [0:0] ARB      = 1'b0;
    localparam logic [0:0] WR_BURST = 1'b1;

    localparam logic [ID_W-1:0]            LAST_ID    = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]           FIFO_DEPTH = CNT_W'(MAX_READS_IN_FLIGHT);
    localparam logic [BURST_CNT_WIDTH-1:0] ONE_BEAT   = BURST_CNT_WIDTH'(1);

    logic [0:0]                 state;
    logic [ID_W-1:0]            rr_ptr;
    logic [ID_W-1:0]            wr_owner;
    logic [BURST_CNT_WIDTH-1:0] beats_left;
    logic [ID_W-1:0]            grant_id;
    logic                       grant_valid;
    logic [ID_W-1:0]            next_ptr;
    logic                       g_read;
    logic                       g_write;
    logic [BURST_CNT_WIDTH-1:0] g_bc_raw;
    logic [BURST_CNT_WIDTH-1:0] g_bc;
    logic                       rd_cmd;
    logic                       wr_cmd;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       rd_accept;
    logic                       wr_accept;
    logic                       wr_done;

    logic [ID_W-1:0]            fifo_id [MAX_READS_IN_FLIGHT];
    logic [BURST_CNT_WIDTH-1:0] fifo_bc [MAX_READS_IN_FLIGHT];
    logic [FIFO_AW-1:0]         fifo_wr_ptr;
    logic [FIFO_AW-1:0]         fifo_rd_ptr;
    logic [CNT_W-1:0]           fifo_count;
    logic [BURST_CNT_WIDTH-1:0] resp_beats;
    logic [ID_W-1:0]            head_id;
    logic [BURST_CNT_WIDTH-1:0] head_bc;
    logic                       rsp_beat;
    logic                       fifo_push;
    logic                       fifo_pop;

    // Descending scan so the last hit is the requester nearest at/after rr_ptr.
    always_comb begin : pick_winner
        int idx;
        idx         = 0;
        grant_id    = rr_ptr;
        grant_valid = 1'b0;
        if (state == WR_BURST) begin
            grant_id    = wr_owner;
            grant_valid = 1'b1;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (req_read[idx] || req_write[idx]) begin
                    grant_id    = ID_W'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    assign g_read   = req_read[grant_id];
    assign g_write  = req_write[grant_id];
    assign g_bc_raw = req_burstcount[grant_id*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
    assign g_bc     = (g_bc_raw == '0) ? ONE_BEAT : g_bc_raw;
    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    // A simultaneous read+write is handled as a write; reads never pass mid-burst.
    assign rd_cmd    = grant_valid && g_read && !g_write && (state == ARB);
    assign wr_cmd    = grant_valid && g_write;
    assign mem_read  = !reset && rd_cmd && !fifo_full;
    assign mem_write = !reset && wr_cmd;
    assign rd_accept = mem_read && !mem_waitrequest;
    assign wr_accept = mem_write && !mem_waitrequest;
    assign wr_done   = wr_accept && (((state == ARB) && (g_bc == ONE_BEAT)) ||
                                     ((state == WR_BURST) && (beats_left == ONE_BEAT)));

    assign mem_address    = req_address[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem_burstcount = g_bc_raw;
    assign mem_writedata  = req_writedata[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign mem_byteenable = req_byteenable[grant_id*BE_W +: BE_W];

    always_comb begin
        req_waitrequest = '1;
        if (!reset && grant_valid) begin
            req_waitrequest[grant_id] = mem_waitrequest || (rd_cmd && fifo_full);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            rr_ptr     <= '0;
            wr_owner   <= '0;
            beats_left <= '0;
        end else begin
            if (rd_accept || wr_done) rr_ptr <= next_ptr;
            if (state == ARB) begin
                if (wr_accept && (g_bc != ONE_BEAT)) begin
                    state      <= WR_BURST;
                    wr_owner   <= grant_id;
                    beats_left <= g_bc - 1'b1;
                end
            end else if (wr_accept) begin
                beats_left <= beats_left - 1'b1;
                if (beats_left == ONE_BEAT) state <= ARB;
            end
        end
    end

    // Routing FIFO: full is judged before any same-cycle pop, so a push on full is refused.
    assign fifo_full  = (fifo_count == FIFO_DEPTH);
    assign fifo_empty = (fifo_count == '0);
    assign head_id    = fifo_id[fifo_rd_ptr];
    assign head_bc    = fifo_bc[fifo_rd_ptr];
    assign rsp_beat   = mem_readdatavalid && !fifo_empty;
    assign fifo_push  = rd_accept;
    assign fifo_pop   = rsp_beat && (resp_beats == head_bc - 1'b1);

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_id[fifo_wr_ptr] <= grant_id;
            fifo_bc[fifo_wr_ptr] <= g_bc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_count  <= '0;
            resp_beats  <= '0;
        end else begin
            if (fifo_push) fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            if (fifo_pop)  fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            if (rsp_beat) resp_beats <= fifo_pop ? '0 : resp_beats + 1'b1;
        end
    end

    assign req_readdata = mem_readdata;

    always_comb begin
        req_readdatavalid = '0;
        if (!reset && rsp_beat) req_readdatavalid[head_id] = 1'b1;
    end

`ifdef OFS_PLAT_AVALON_MEM_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
        end else if (rd_accept || wr_done) begin
            grant_cnt[grant_id] <= grant_cnt[grant_id] + 32'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_grants[gi*32 +: 32] = grant_cnt[gi];
    end
`else
    assign stat_grants = '0;
`endif

`ifndef SYNTHESIS
    a_no_read_and_write: assert property (@(posedge clk) disable iff (reset)
        !(|(req_read & req_write)));
    a_no_orphan_response: assert property (@(posedge clk) disable iff (reset)
        !(mem_readdatavalid && fifo_empty));
`endif

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rr_arbiter.sv
// Randomized self-checking bench for ofs_plat_avalon_mem_rr_arbiter: requester agents, a bank model
// and a transaction-level round-robin reference model compared against the DUT every cycle.
module tb_ofs_plat_avalon_mem_rr_arbiter;

   localparam int N    = 3;
   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int BCW  = 4;
   localparam int MAXR = 4;

   logic              clk;
   logic              reset;
   logic [N*AW-1:0]   req_address;
   logic [N-1:0]      req_read;
   logic [N-1:0]      req_write;
   logic [N*BCW-1:0]  req_burstcount;
   logic [N*DW-1:0]   req_writedata;
   logic [N*DW/8-1:0] req_byteenable;
   logic [N-1:0]      req_waitrequest;
   logic [DW-1:0]     req_readdata;
   logic [N-1:0]      req_readdatavalid;
   logic [AW-1:0]     mem_address;
   logic              mem_read;
   logic              mem_write;
   logic [BCW-1:0]    mem_burstcount;
   logic [DW-1:0]     mem_writedata;
   logic [DW/8-1:0]   mem_byteenable;
   logic              mem_waitrequest;
   logic [DW-1:0]     mem_readdata;
   logic              mem_readdatavalid;
   logic [N*32-1:0]   stat_grants;

   ofs_plat_avalon_mem_rr_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .BURST_CNT_WIDTH(BCW), .MAX_READS_IN_FLIGHT(MAXR)
   ) dut (
      .clk(clk), .reset(reset),
      .req_address(req_address), .req_read(req_read), .req_write(req_write),
      .req_burstcount(req_burstcount), .req_writedata(req_writedata),
      .req_byteenable(req_byteenable), .req_waitrequest(req_waitrequest),
      .req_readdata(req_readdata), .req_readdatavalid(req_readdatavalid),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_burstcount(mem_burstcount), .mem_writedata(mem_writedata),
      .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
      .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
      .stat_grants(stat_grants)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   // Requester agents: one outstanding command each, held until the model says it was taken.
   logic          act [N];
   logic          is_wr [N];
   logic [AW-1:0] a_addr [N];
   logic [BCW-1:0] a_bc [N];
   int            a_beat [N];
   int            gen_pct, wait_pct, rv_pct;

   // Reference model state: fairness pointer, burst lock, outstanding reads and expected data.
   int            ptr;
   int            lock_owner;
   int            lock_left;
   int            oq_id [$];
   int            oq_left [$];
   logic [DW-1:0] exp_data [N][$];
   logic [DW-1:0] bank_q [$];
   int            stat_exp [N];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int eff(input logic [BCW-1:0] bc);
      return (bc == '0) ? 1 : int'(bc);
   endfunction

   function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
      return {a, a ^ 16'h5A3C};
   endfunction

   function automatic logic [DW-1:0] expWdata(input int i);
      return {a_addr[i], 8'(i), 8'(a_beat[i])};
   endfunction

   function automatic logic [DW/8-1:0] expBe(input int i);
      return a_addr[i][3:0] ^ 4'(a_beat[i]);
   endfunction

   function automatic logic allIdle();
      logic busy;
      busy = (oq_id.size() != 0) || (bank_q.size() != 0);
      for (int i = 0; i < N; i++) busy = busy || act[i];
      return !busy;
   endfunction

   task automatic driveBus();
      for (int i = 0; i < N; i++) begin
         req_read[i]                   = act[i] && !is_wr[i];
         req_write[i]                  = act[i] && is_wr[i];
         req_address[i*AW +: AW]       = a_addr[i];
         req_burstcount[i*BCW +: BCW]  = a_bc[i];
         req_writedata[i*DW +: DW]     = expWdata(i);
         req_byteenable[i*DW/8 +: DW/8] = expBe(i);
      end
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < N; i++) begin
         if (!act[i] && gen_pct > 0 && $urandom_range(0, 99) < gen_pct) begin
            act[i]    = 1'b1;
            is_wr[i]  = 1'($urandom_range(0, 1));
            a_addr[i] = {2'(i), 14'($urandom)};
            a_bc[i]   = is_wr[i] ? BCW'($urandom_range(0, 5)) : BCW'($urandom_range(0, 3));
            a_beat[i] = 0;
         end
      end
      driveBus();
      mem_waitrequest = ($urandom_range(0, 99) < wait_pct);
      if (bank_q.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
         mem_readdatavalid = 1'b1;
         mem_readdata      = bank_q.pop_front();
      end else begin
         mem_readdatavalid = 1'b0;
         mem_readdata      = $urandom;
      end
   endtask

   task automatic modelAndCheck();
      int g;
      logic gv, full, exp_rd, exp_wr;
      logic [N-1:0] exp_wait, exp_rdv;
      g  = 0;
      gv = 1'b0;
      if (lock_owner >= 0) begin
         g  = lock_owner;
         gv = 1'b1;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!gv && act[(ptr + k) % N]) begin
               g  = (ptr + k) % N;
               gv = 1'b1;
            end
         end
      end
      full   = (oq_id.size() >= MAXR);
      exp_rd = gv && act[g] && !is_wr[g] && !full;
      exp_wr = gv && act[g] && is_wr[g];
      exp_wait = '1;
      if (gv) exp_wait[g] = mem_waitrequest || (act[g] && !is_wr[g] && full);
      checkOutput("waitreq", 64'(req_waitrequest), 64'(exp_wait));
      checkOutput("mem_cmd", 64'({mem_read, mem_write}), 64'({exp_rd, exp_wr}));
      if (exp_rd || exp_wr) begin
         checkOutput("mem_addr_bc_be", 64'({mem_address, mem_burstcount, mem_byteenable}),
                     64'({a_addr[g], a_bc[g], expBe(g)}));
         if (exp_wr) checkOutput("mem_wdata", 64'(mem_writedata), 64'(expWdata(g)));
      end

      exp_rdv = '0;
      if (mem_readdatavalid && oq_id.size() > 0) exp_rdv[oq_id[0]] = 1'b1;
      checkOutput("rdvalid", 64'(req_readdatavalid), 64'(exp_rdv));
      for (int i = 0; i < N; i++) begin
         if (req_readdatavalid[i]) begin
            if (exp_data[i].size() > 0) checkOutput("rddata", 64'(req_readdata), 64'(exp_data[i].pop_front()));
            else checkOutput("rddata_orphan", 64'(1), 64'(0));
         end
      end
      if (mem_readdatavalid && oq_id.size() > 0) begin
         oq_left[0] = oq_left[0] - 1;
         if (oq_left[0] == 0) begin
            void'(oq_id.pop_front());
            void'(oq_left.pop_front());
         end
      end

      if (mem_read && !mem_waitrequest) begin
         for (int k = 0; k < eff(mem_burstcount); k++) bank_q.push_back(rdata(mem_address + AW'(k)));
      end

      if (exp_rd && !mem_waitrequest) begin
         oq_id.push_back(g);
         oq_left.push_back(eff(a_bc[g]));
         for (int k = 0; k < eff(a_bc[g]); k++) exp_data[g].push_back(rdata(a_addr[g] + AW'(k)));
         ptr = (g + 1) % N;
         stat_exp[g]++;
         act[g] = 1'b0;
      end
      if (exp_wr && !mem_waitrequest) begin
         if (lock_owner < 0) begin
            if (eff(a_bc[g]) > 1) begin
               lock_owner = g;
               lock_left  = eff(a_bc[g]) - 1;
            end else begin
               ptr = (g + 1) % N;
               stat_exp[g]++;
            end
         end else begin
            lock_left--;
            if (lock_left == 0) begin
               lock_owner = -1;
               ptr = (g + 1) % N;
               stat_exp[g]++;
            end
         end
         a_beat[g]++;
         if (a_beat[g] >= eff(a_bc[g])) act[g] = 1'b0;
      end
   endtask

   task automatic doCycle();
      @(negedge clk);
      applyStimulus();
      #2;
      modelAndCheck();
   endtask

   task automatic checkStats();
      for (int i = 0; i < N; i++) begin
`ifdef OFS_PLAT_AVALON_MEM_ARB_STATS_EN
         checkOutput("stat_grants", 64'(stat_grants[i*32 +: 32]), 64'(stat_exp[i]));
`else
         checkOutput("stat_grants", 64'(stat_grants[i*32 +: 32]), 64'(0));
`endif
      end
   endtask

   task automatic clearModel();
      ptr = 0;
      lock_owner = -1;
      lock_left = 0;
      oq_id.delete();
      oq_left.delete();
      bank_q.delete();
      for (int i = 0; i < N; i++) begin
         exp_data[i].delete();
         stat_exp[i] = 0;
         act[i] = 1'b0;
         is_wr[i] = 1'b0;
         a_addr[i] = '0;
         a_bc[i] = '0;
         a_beat[i] = 0;
      end
   endtask

   task automatic drain();
      gen_pct  = 0;
      wait_pct = 0;
      rv_pct   = 100;
      for (int c = 0; c < 200 && !allIdle(); c++) doCycle();
      checkOutput("drain_timeout", 64'(allIdle()), 64'(1));
   endtask

   int ph_gen  [4] = '{95, 60, 90, 30};
   int ph_wait [4] = '{0, 30, 10, 50};
   int ph_rv   [4] = '{100, 50, 15, 80};

   initial begin
      clearModel();
      gen_pct = 0; wait_pct = 0; rv_pct = 100;
      reset = 1'b1;
      driveBus();
      req_read = '1;
      mem_waitrequest = 1'b0;
      mem_readdatavalid = 1'b1;
      mem_readdata = '0;
      #2;
      checkOutput("reset_waitreq", 64'(req_waitrequest), 64'({N{1'b1}}));
      checkOutput("reset_mem_cmd", 64'({mem_read, mem_write}), 64'(0));
      checkOutput("reset_rdvalid", 64'(req_readdatavalid), 64'(0));
      checkStats();
      @(negedge clk);
      driveBus();
      mem_readdatavalid = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      for (int p = 0; p < 4; p++) begin
         gen_pct = ph_gen[p]; wait_pct = ph_wait[p]; rv_pct = ph_rv[p];
         for (int c = 0; c < 300; c++) doCycle();
      end
      drain();
      checkStats();

      // Reset in the middle of a 4-beat write, two beats already taken.
      act[0] = 1'b1; is_wr[0] = 1'b1; a_addr[0] = 16'h0123; a_bc[0] = 4'd4; a_beat[0] = 0;
      doCycle();
      doCycle();
      @(negedge clk);
      applyStimulus();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midburst_reset_waitreq", 64'(req_waitrequest), 64'({N{1'b1}}));
      checkOutput("midburst_reset_mem_cmd", 64'({mem_read, mem_write}), 64'(0));
      checkOutput("midburst_reset_rdvalid", 64'(req_readdatavalid), 64'(0));
      clearModel();
      driveBus();
      mem_readdatavalid = 1'b0;
      checkStats();
      @(negedge clk);
      reset = 1'b0;
      act[1] = 1'b1; is_wr[1] = 1'b0; a_addr[1] = 16'h4567; a_bc[1] = 4'd2; a_beat[1] = 0;
      doCycle();
      drain();
      checkStats();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
